load_extend: RTL and testbench
==============================

LOAD_EXTEND -- requirements
Module: load_extend

Interface
REQ-001 The block SHALL accept parameter TIMEOUT, default 16, giving the maximum number of mem_rd cycles before abort (legal range 1-255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port l_start, input, 1, a load request sampled only in IDLE.
REQ-005 The block SHALL have port l_type, input, 3, the load kind: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu; 5-7 are illegal.
REQ-006 The block SHALL have port l_addr, input, 32, the byte address of the load.
REQ-007 The block SHALL have port mem_addr, output, 32, the word-aligned read address.
REQ-008 The block SHALL have port mem_rd, output, 1, the read strobe.
REQ-009 The block SHALL have port mem_ready, input, 1, the memory response valid for mem_rdata.
REQ-010 The block SHALL have port mem_rdata, input, 32, the memory read word.
REQ-011 The block SHALL have port l_busy, output, 1, high in every state except IDLE.
REQ-012 The block SHALL have port l_done, output, 1, a one-cycle completion pulse.
REQ-013 The block SHALL have port l_err, output, 1, qualified by l_done: 1 = address error, illegal type, or timeout.
REQ-014 The block SHALL have port l_data, output, 32, the registered, extended load result, held until the next successful load.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DONE and FAIL.
REQ-016 In IDLE with l_start=1, the block SHALL register l_type and l_addr and go to READ; if the type is illegal or the access is misaligned, it SHALL go to FAIL instead.
- Misaligned: lw with addr[1:0]!=0; lh/lhu with addr[0]!=0.
REQ-017 In READ the block SHALL drive mem_rd=1 and mem_addr={addr[31:2],2'b00} from the registered values, holding both stable until exit.
REQ-018 In READ, when mem_ready=1 is sampled, the block SHALL load l_data with the extracted value and go to DONE.
REQ-019 Extraction SHALL follow these rules:
- lw: whole word.
- lh/lhu: addr[1]=0 selects bits [15:0], addr[1]=1 selects [31:16].
- lb/lbu: addr[1:0]=0..3 selects byte [7:0], [15:8], [23:16], [31:24].
- lh/lb sign-extend; lhu/lbu zero-extend to 32 bits.
REQ-020 A wait counter SHALL clear on entry to READ and increment each READ cycle without mem_ready; when TIMEOUT cycles have elapsed without mem_ready, the block SHALL go to FAIL with l_data unchanged.
REQ-021 DONE SHALL assert l_done=1 and l_err=0 for exactly one cycle, then return to IDLE.
REQ-022 FAIL SHALL assert l_done=1 and l_err=1 for exactly one cycle with mem_rd=0, then return to IDLE.
REQ-023 Latency SHALL be as follows:
- l_start accepted at cycle 0 gives mem_rd high from cycle 1.
- mem_ready first high at cycle k gives l_done at cycle k+1 (minimum 2).
- An error detected at request gives l_done at cycle 1.
REQ-024 The block SHALL ignore l_start outside IDLE, and the request SHALL NOT be queued.
REQ-025 The block SHALL ignore mem_ready outside READ.
REQ-026 If mem_ready=1 arrives in the same cycle the timeout would fire, mem_ready SHALL win and the load SHALL complete successfully.
REQ-027 In IDLE, mem_rd, l_done and l_err SHALL be 0 and mem_addr SHALL be 0.

Reset
REQ-028 With reset=1 at a clock edge, the block SHALL go to IDLE and clear to 0: l_data, l_done, l_err, l_busy, mem_rd, mem_addr, the wait counter and the registered request.
REQ-029 Reset SHALL take priority over all other inputs, including mid-READ: mem_rd falls on the next cycle and no l_done is produced for the aborted load.

Verification
REQ-030 lb, addr=0x1003, mem_rdata=0x80FF1234, mem_ready at cycle 1 -> mem_addr=0x1000, l_done at cycle 2, l_err=0, l_data=0xFFFFFF80.
REQ-031 lhu, addr=0x2002, mem_rdata=0x9ABC5678, mem_ready at cycle 3 -> mem_rd high for cycles 1-3, l_data=0x00009ABC at l_done in cycle 4; repeat as lh -> l_data=0xFFFF9ABC.
REQ-032 lw, addr=0x3001 -> l_done=1 and l_err=1 at cycle 1, mem_rd never asserted, l_data unchanged; l_type=6 -> same response.
REQ-033 lw with mem_ready held 0 and TIMEOUT=16 -> mem_rd high for 16 cycles, then l_done=1 and l_err=1, l_data unchanged; a separate case with mem_ready high on the 16th cycle -> success.
REQ-034 A second l_start while busy -> ignored, exactly one l_done; reset asserted during READ -> next cycle IDLE, all outputs 0, no l_done.

Source files
------------

// File: rtl/load_extend_if.sv
// load_extend_if: request, memory-read and result signals of the load/extend unit
interface load_if;
    logic        l_start;
    logic [2:0]  l_type;
    logic [31:0] l_addr;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        l_busy;
    logic        l_done;
    logic        l_err;
    logic [31:0] l_data;
    modport slave (
        input  l_start, l_type, l_addr, mem_ready, mem_rdata,
        output mem_addr, mem_rd, l_busy, l_done, l_err, l_data
    );
    modport master (
        output l_start, l_type, l_addr, mem_ready, mem_rdata,
        input  mem_addr, mem_rd, l_busy, l_done, l_err, l_data
    );
endinterface

// File: rtl/load_extend.sv
// load_extend: single-word memory read with lw/lh/lhu/lb/lbu extraction, alignment check and timeout
module load_extend #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic   clk,
    input logic   reset,
    load_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE, FAIL} state_t;
    state_t      state, state_nx;
    logic [2:0]  type_r;
    logic [31:0] addr_r;
    logic [7:0]  cnt;
    logic        bad;
    logic        expired;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] ext;
    // Reject illegal kinds and misaligned word/halfword accesses at request time
    always_comb begin
        bad = bus.l_type > 3'd4
            || (bus.l_type == 3'd0 && bus.l_addr[1:0] != 2'b00)
            || ((bus.l_type == 3'd1 || bus.l_type == 3'd2) && bus.l_addr[0]);
    end
    // Select the addressed halfword/byte of the returned word and extend it
    always_comb begin
        half   = addr_r[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        byte_v = addr_r[1:0] == 2'd0 ? bus.mem_rdata[7:0]
               : addr_r[1:0] == 2'd1 ? bus.mem_rdata[15:8]
               : addr_r[1:0] == 2'd2 ? bus.mem_rdata[23:16]
               :                       bus.mem_rdata[31:24];
        ext    = type_r == 3'd1 ? {{16{half[15]}}, half}
               : type_r == 3'd2 ? {16'd0, half}
               : type_r == 3'd3 ? {{24{byte_v[7]}}, byte_v}
               : type_r == 3'd4 ? {24'd0, byte_v}
               :                  bus.mem_rdata;
    end
    assign expired = cnt == 8'(TIMEOUT - 1);
    // Next-state logic; mem_ready outranks a timeout landing in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.l_start ? (bad ? FAIL : READ) : IDLE;
            READ:    state_nx = bus.mem_ready ? DONE : (expired ? FAIL : READ);
            default: state_nx = IDLE;
        endcase
    end
    // State, captured request, wait counter and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            type_r <= '0;
            addr_r <= '0;
            cnt    <= '0;
            bus.l_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state == READ ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && bus.l_start) begin
                type_r <= bus.l_type;
                addr_r <= bus.l_addr;
            end
            if (state == READ && bus.mem_ready)
                bus.l_data <= ext;
        end
    end
    assign bus.mem_rd   = state == READ;
    assign bus.mem_addr = state == READ ? {addr_r[31:2], 2'b00} : 32'd0;
    assign bus.l_busy   = state != IDLE;
    assign bus.l_done   = state == DONE || state == FAIL;
    assign bus.l_err    = state == FAIL;
endmodule

// File: tb/tb_load_extend.sv
// tb_load_extend: directed loads checked against a transaction-level model plus literal expectations
module tb_load_extend;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    load_if bus();
    load_extend #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] model_ext(input int t, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        v = d;
        if (t == 1 || t == 2) begin
            v = (d >> (int'(a[1]) * 16)) & 32'hFFFF;
            if (t == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else if (t == 3 || t == 4) begin
            v = (d >> (int'(a[1:0]) * 8)) & 32'hFF;
            if (t == 3 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end
        return v;
    endfunction
    function automatic bit model_bad(input int t, input logic [31:0] a);
        return t > 4 || (t == 0 && (a % 4) != 0) || ((t == 1 || t == 2) && (a % 2) != 0);
    endfunction
    // Model: an outstanding read (with its elapsed wait) and a pending completion report
    initial begin
        bit armed, m_read, m_done, m_err;
        int m_wait, m_type;
        logic [31:0] m_addr, m_data;
        armed = 0; m_read = 0; m_done = 0; m_err = 0;
        m_wait = 0; m_type = 0; m_addr = 0; m_data = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("mem_rd", 32'(bus.mem_rd), 32'(m_read));
                chk("mem_addr", bus.mem_addr, m_read ? (m_addr & ~32'h3) : 32'd0);
                chk("l_busy", 32'(bus.l_busy), 32'(m_read || m_done));
                chk("l_done", 32'(bus.l_done), 32'(m_done));
                chk("l_err", 32'(bus.l_err), 32'(m_done && m_err));
                chk("l_data", bus.l_data, m_data);
            end
            if (reset) begin
                armed = 1; m_read = 0; m_done = 0; m_err = 0; m_data = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_read) begin
                if (bus.mem_ready) begin
                    m_data = model_ext(m_type, m_addr, bus.mem_rdata);
                    m_read = 0; m_done = 1; m_err = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_read = 0; m_done = 1; m_err = 1;
                    end
                end
            end else if (bus.l_start) begin
                m_type = int'(bus.l_type);
                m_addr = bus.l_addr;
                if (model_bad(m_type, m_addr)) begin
                    m_done = 1; m_err = 1;
                end else begin
                    m_read = 1; m_wait = 0;
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [2:0] t, input logic [31:0] a);
        bus.l_type  = t;
        bus.l_addr  = a;
        bus.l_start = 1'b1;
        step();
        bus.l_start = 1'b0;
    endtask
    task automatic half_case(input logic [2:0] t, input logic [31:0] exp);
        bus.mem_rdata = 32'h9ABC5678;
        start(t, 32'h2002);
        chk("031_rd_c1", 32'(bus.mem_rd), 32'd1);
        step();
        chk("031_rd_c2", 32'(bus.mem_rd), 32'd1);
        step();
        chk("031_rd_c3", 32'(bus.mem_rd), 32'd1);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("031_done", 32'(bus.l_done), 32'd1);
        chk("031_err", 32'(bus.l_err), 32'd0);
        chk("031_data", bus.l_data, exp);
        step();
    endtask
    typedef struct {logic [2:0] t; logic [31:0] a; logic [31:0] exp;} vec_t;
    vec_t vecs[7] = '{
        '{3'd4, 32'h0000_0100, 32'h0000_0001},
        '{3'd3, 32'h0000_0101, 32'hFFFF_FFC0},
        '{3'd4, 32'h0000_0102, 32'h0000_0080},
        '{3'd3, 32'h0000_0103, 32'h0000_007F},
        '{3'd1, 32'h0000_0100, 32'hFFFF_C001},
        '{3'd2, 32'h0000_0102, 32'h0000_7F80},
        '{3'd0, 32'h0000_0104, 32'h7F80_C001}
    };
    initial begin
        int n;
        bus.l_start = 0; bus.l_type = 0; bus.l_addr = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        repeat (3) step();
        chk("rst_busy", 32'(bus.l_busy), 32'd0);
        chk("rst_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_data", bus.l_data, 32'd0);
        reset = 1'b0;
        step();
        bus.mem_rdata = 32'h80FF1234;
        start(3'd3, 32'h1003);
        chk("030_addr", bus.mem_addr, 32'h1000);
        chk("030_rd", 32'(bus.mem_rd), 32'd1);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("030_done", 32'(bus.l_done), 32'd1);
        chk("030_err", 32'(bus.l_err), 32'd0);
        chk("030_data", bus.l_data, 32'hFFFFFF80);
        step();
        half_case(3'd2, 32'h00009ABC);
        half_case(3'd1, 32'hFFFF9ABC);
        start(3'd0, 32'h3001);
        chk("032_done", 32'(bus.l_done), 32'd1);
        chk("032_err", 32'(bus.l_err), 32'd1);
        chk("032_rd", 32'(bus.mem_rd), 32'd0);
        chk("032_data", bus.l_data, 32'hFFFF9ABC);
        step();
        start(3'd6, 32'h1000);
        chk("032_t6_done", 32'(bus.l_done), 32'd1);
        chk("032_t6_err", 32'(bus.l_err), 32'd1);
        chk("032_t6_data", bus.l_data, 32'hFFFF9ABC);
        step();
        n = 0;
        start(3'd0, 32'h4000);
        for (int i = 0; i < TO; i++) begin
            n += int'(bus.mem_rd);
            step();
        end
        chk("033_rd_cycles", n, TO);
        chk("033_done", 32'(bus.l_done), 32'd1);
        chk("033_err", 32'(bus.l_err), 32'd1);
        chk("033_data", bus.l_data, 32'hFFFF9ABC);
        step();
        bus.mem_rdata = 32'hCAFEF00D;
        start(3'd0, 32'h5004);
        repeat (TO - 1) step();
        chk("033_rd_last", 32'(bus.mem_rd), 32'd1);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("033_win_done", 32'(bus.l_done), 32'd1);
        chk("033_win_err", 32'(bus.l_err), 32'd0);
        chk("033_win_data", bus.l_data, 32'hCAFEF00D);
        step();
        bus.mem_rdata = 32'h11223344;
        n = 0;
        start(3'd4, 32'h6001);
        bus.l_start = 1'b1; bus.l_type = 3'd0; bus.l_addr = 32'h7000;
        step();
        n += int'(bus.l_done);
        bus.mem_ready = 1'b1;
        step();
        n += int'(bus.l_done);
        bus.l_start = 1'b0; bus.mem_ready = 1'b0;
        repeat (5) begin
            step();
            n += int'(bus.l_done);
        end
        chk("034_one_done", n, 1);
        chk("034_data", bus.l_data, 32'h00000033);
        start(3'd0, 32'h8000);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("034_rst_rd", 32'(bus.mem_rd), 32'd0);
        chk("034_rst_busy", 32'(bus.l_busy), 32'd0);
        chk("034_rst_addr", bus.mem_addr, 32'd0);
        chk("034_rst_data", bus.l_data, 32'd0);
        n = int'(bus.l_done);
        bus.mem_ready = 1'b1;
        repeat (4) begin
            step();
            n += int'(bus.l_done);
        end
        bus.mem_ready = 1'b0;
        chk("034_rst_no_done", n, 0);
        bus.mem_rdata = 32'h7F80C001;
        foreach (vecs[i]) begin
            start(vecs[i].t, vecs[i].a);
            bus.mem_ready = 1'b1;
            step();
            bus.mem_ready = 1'b0;
            chk($sformatf("ext_%0d", i), bus.l_data, vecs[i].exp);
            step();
        end
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
